// File: rtl/sb_cfg_shadow_array.sv
// Switch-block mux column with a double-buffered ccff configuration: the serial shadow
// chain loads while the active words keep driving routing, and a commit copies it across.

module sb_cfg_mux_lane #(
    parameter int MUX_SIZE = 5,
    parameter int SEL_W    = 3
) (
    input  logic                en,
    input  logic [SEL_W-1:0]    sel,
    input  logic [MUX_SIZE-1:0] in_vec,
    output logic                y
);
    // Out-of-range selects match no input and leave the track at 0
    always_comb begin
        y = 1'b0;
        if (en) begin
            for (int j = 0; j < MUX_SIZE; j++) begin
                if (sel == SEL_W'(j)) y = in_vec[j];
            end
        end
    end
endmodule

module sb_cfg_shadow_array #(
    parameter int NUM_MUX  = 4,
    parameter int MUX_SIZE = 5,
    parameter int OUT_REG  = 0
) (
    input  logic                        prog_clk,
    input  logic                        pReset,
    input  logic                        ccff_head,
    input  logic                        ccff_shift_en,
    input  logic                        ccff_commit,
    input  logic [NUM_MUX*MUX_SIZE-1:0] mux_in,
    output logic [NUM_MUX-1:0]          chan_out,
    output logic                        ccff_tail,
    output logic                        cfg_done,
    output logic                        cfg_err
);
    localparam int SEL_W     = $clog2(MUX_SIZE);
    localparam int CFG_W     = SEL_W + 1;
    localparam int CHAIN_LEN = NUM_MUX * CFG_W;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    state_t                           state, state_nxt;
    logic [CHAIN_LEN-1:0]             sh, sh_nxt;
    logic [NUM_MUX-1:0][CFG_W-1:0]    active, active_nxt;
    logic [CNT_W-1:0]                 bit_cnt, cnt_nxt;
    logic                             done_nxt, err_nxt;
    logic [NUM_MUX-1:0]               mux_y;

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state    <= IDLE;
            sh       <= '0;
            active   <= '0;
            bit_cnt  <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            sh       <= sh_nxt;
            active   <= active_nxt;
            bit_cnt  <= cnt_nxt;
            cfg_done <= done_nxt;
            cfg_err  <= err_nxt;
        end
    end

    // Commit has priority over shift so a simultaneous request never moves the chain
    always_comb begin
        state_nxt  = state;
        sh_nxt     = sh;
        active_nxt = active;
        cnt_nxt    = bit_cnt;
        done_nxt   = 1'b0;
        err_nxt    = cfg_err;
        if (ccff_commit) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
            if (state == FULL) begin
                active_nxt = sh;
                done_nxt   = 1'b1;
                err_nxt    = 1'b0;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (ccff_shift_en) begin
            sh_nxt = {sh[CHAIN_LEN-2:0], ccff_head};
            if (state == FULL) begin
                err_nxt = 1'b1;
            end else begin
                if (bit_cnt != CNT_W'(CHAIN_LEN)) cnt_nxt = bit_cnt + 1'b1;
                state_nxt = (cnt_nxt == CNT_W'(CHAIN_LEN)) ? FULL : SHIFT;
            end
        end
    end

    assign ccff_tail = sh[CHAIN_LEN-1];

    for (genvar i = 0; i < NUM_MUX; i++) begin : g_lane
        sb_cfg_mux_lane #(.MUX_SIZE(MUX_SIZE), .SEL_W(SEL_W)) u_lane (
            .en     (active[i][CFG_W-1]),
            .sel    (active[i][SEL_W-1:0]),
            .in_vec (mux_in[i*MUX_SIZE +: MUX_SIZE]),
            .y      (mux_y[i])
        );
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [NUM_MUX-1:0] chan_q;
        always_ff @(posedge prog_clk or negedge pReset) begin
            if (!pReset) chan_q <= '0;
            else         chan_q <= mux_y;
        end
        assign chan_out = chan_q;
    end else begin : g_ocomb
        assign chan_out = mux_y;
    end
endmodule

// File: doc/sb_cfg_shadow_array.md
Name: sb_cfg_shadow_array

Overview:
- Parametrised successor to the fixed-size switch-block mux columns: an array of NUM_MUX routing muxes, each MUX_SIZE wide, configured through the ccff chain.
- Adds a double-buffered configuration: a shift shadow plus an active register, so routing never glitches while the chain loads.
- Adds per-mux enable, bit-count checking, a commit handshake and an optional registered output.
- Sits inside a switch-block tile; the tile's ccff_head/ccff_tail join the fabric-wide configuration chain.

Parameters:
- NUM_MUX, 4, number of routing muxes (output tracks).
- MUX_SIZE, 5, inputs per mux (≥2).
- SEL_W, $clog2(MUX_SIZE), select field width (localparam).
- CFG_W, SEL_W+1, per-mux config word {en, sel} (localparam).
- CHAIN_LEN, NUM_MUX*CFG_W, shadow chain length (localparam).
- OUT_REG, 0, 1 = register chan_out on prog_clk; 0 = combinational.

Ports:
- prog_clk  in  1  sole clock.
- pReset  in  1  asynchronous, active-low reset.
- ccff_head  in  1  serial config data in.
- ccff_shift_en  in  1  shift one chain bit this cycle.
- ccff_commit  in  1  request copy of shadow into active config.
- mux_in  in  NUM_MUX*MUX_SIZE  mux i input j = mux_in[i*MUX_SIZE+j].
- chan_out  out  NUM_MUX  routed track outputs.
- ccff_tail  out  1  serial config data out (chain MSB).
- cfg_done  out  1  one-cycle pulse on accepted commit.
- cfg_err  out  1  sticky length/overflow error.

Behaviour:
- Reset (pReset=0, async): shadow=0, active=0, bit_cnt=0, state=IDLE, cfg_done=0, cfg_err=0, chan_out=0 (active en=0 everywhere), ccff_tail=0.
- Shift: when ccff_shift_en=1, sh <= {sh[CHAIN_LEN-2:0], ccff_head}; ccff_tail = sh[CHAIN_LEN-1] (combinational from the register). The first bit shifted in ends at the en bit of mux NUM_MUX-1.
- bit_cnt width is $clog2(CHAIN_LEN+1). It increments per shift and saturates at CHAIN_LEN.
- Word map: mux i word = active[i*CFG_W +: CFG_W]. The MSB is en; the low SEL_W bits are sel.
- Mux output:
  - en=0 -> 0.
  - en=1 and sel<MUX_SIZE -> mux_in[i*MUX_SIZE+sel].
  - en=1 and sel>=MUX_SIZE -> 0.
- OUT_REG=1 adds exactly 1 prog_clk cycle of latency on chan_out; its reset value is 0.
- FSM states IDLE, SHIFT, FULL:
  - IDLE -> SHIFT on first shift_en.
  - SHIFT -> FULL when bit_cnt reaches CHAIN_LEN.
  - FULL + shift_en -> stays FULL. Shadow still shifts (pass-through chain). cfg_err<=1 (overflow).
  - Commit in FULL: active<=shadow, cfg_done=1 next cycle, cfg_err<=0, bit_cnt<=0, -> IDLE.
  - Commit in IDLE/SHIFT: active unchanged, cfg_err<=1, bit_cnt<=0, -> IDLE. Shadow contents are kept.
  - Commit and shift_en in the same cycle: commit wins, the shift is ignored (no data movement).
- cfg_done is high for exactly one cycle per accepted commit. cfg_err holds until the next accepted commit or reset.
- Reset mid-shift or mid-commit: everything returns to reset values immediately, and the active config is lost (chan_out=0).
- Active config changes only on an accepted commit, never during shifting.

Test Plan:
- Reset (NUM_MUX=4, MUX_SIZE=5, CFG_W=4, CHAIN_LEN=16): hold pReset=0 with mux_in all-ones -> chan_out=0000, cfg_done=0, cfg_err=0, ccff_tail=0.
- Load and commit:
  - Stimulus: shift 0xE0CA MSB-first over 16 cycles, then commit (mux0 en/sel2, mux1 en/sel4, mux2 off, mux3 en/sel6).
  - Required: cfg_done pulses 1 cycle; chan_out[0] tracks mux_in[2], chan_out[1] tracks mux_in[9]; chan_out[2]=0 and chan_out[3]=0 regardless of mux_in.
- Glitch-free load: after the config above, shift 16 new bits without commit -> chan_out unchanged every cycle. ccff_tail emits 1,1,1,0,0,0,0,0,1,1,0,0,1,0,1,0 (old chain, MSB first).
- Short load: shift 10 bits then commit -> cfg_err=1, no cfg_done, chan_out unchanged. A later full 16-bit load plus commit -> cfg_err=0, cfg_done pulse.
- Overflow and simultaneity: shift 17 bits -> cfg_err=1 at the 17th. Commit asserted together with shift_en -> shadow not shifted, commit accepted.
- OUT_REG=1 and reset mid-shift: chan_out lags the mux_in toggle by 1 cycle. Assert pReset after 8 shifted bits -> immediate chan_out=0, bit_cnt=0, state IDLE.
